// File: rtl/yuv444_to_yuv422_pkg.sv
// Shared video definitions for the YUV 4:4:4 -> 4:2:2 stage and its neighbours.
package yuv444_to_yuv422_pkg;

  localparam int YUV422_LATENCY = 2;
  localparam int CHROMA_AVG     = 0;
  localparam int CHROMA_DEC     = 1;
  localparam logic [7:0] NEUTRAL_C = 8'h80;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

endpackage

// File: rtl/yuv444_to_yuv422_sync_delay.sv
// N-stage shift register for {vs, hs, de}; every stage is exposed so callers can tap mid-pipeline.
module video_sync_delay
  import yuv444_to_yuv422_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  sync_t                    sync_in,
  output sync_t [STAGES-1:0]       taps
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else begin
      taps[0] <= sync_in;
      for (int i = 1; i < STAGES; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/yuv444_to_yuv422.sv
// Converts per-pixel YUV 4:4:4 into a 16-bit {Y, C} 4:2:2 stream with aligned sync,
// and reports the length of each completed line plus a sticky odd-length flag.
module yuv444_to_yuv422
  import yuv444_to_yuv422_pkg::*;
#(
  parameter int CHROMA_MODE = CHROMA_AVG,
  parameter int CB_FIRST    = 1,
  parameter int LINE_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        y_in,
  input  logic [7:0]        u_in,
  input  logic [7:0]        v_in,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  output logic [15:0]       yc_out,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [LINE_W-1:0] line_len,
  output logic              odd_line_err
);

  function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction

  sync_t                sync_in;
  sync_t [2:0]          sync_taps;
  logic                 vld_p1, vld_p2, vs_p2;
  logic [7:0]           y_p1, u_p1, v_p1;
  logic [7:0]           y_p2, u_p2, v_p2;
  logic                 phase;
  logic [7:0]           c_hold;
  logic [LINE_W-1:0]    line_cnt;
  logic [7:0]           cu, cv, c_first, c_second, c_sel;

  assign sync_in = {vs_in, hs_in, de_in};

  // Stage taps: [0] = s1, [1] = s2, [2] = output register.
  video_sync_delay #(.STAGES(YUV422_LATENCY + 1)) u_sync_delay (
    .clk     (clk),
    .rst     (rst),
    .sync_in (sync_in),
    .taps    (sync_taps)
  );

  assign vld_p1 = sync_taps[0].de;
  assign vld_p2 = sync_taps[1].de;
  assign vs_p2  = sync_taps[1].vs;
  assign vs_out = sync_taps[2].vs;
  assign hs_out = sync_taps[2].hs;
  assign de_out = sync_taps[2].de;

  // ---- s1 / s2 pixel stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_p1 <= '0;
      u_p1 <= '0;
      v_p1 <= '0;
      y_p2 <= '0;
      u_p2 <= '0;
      v_p2 <= '0;
    end else begin
      y_p1 <= y_in;
      u_p1 <= u_in;
      v_p1 <= v_in;
      y_p2 <= y_p1;
      u_p2 <= u_p1;
      v_p2 <= v_p1;
    end
  end

  // The partner of an even pixel sits in s1; without it the pixel keeps its own chroma.
  always_comb begin
    cu = u_p2;
    cv = v_p2;
    if (CHROMA_MODE == CHROMA_AVG && vld_p1) begin
      cu = avg_round(u_p2, u_p1);
      cv = avg_round(v_p2, v_p1);
    end
    c_first  = (CB_FIRST != 0) ? cu : cv;
    c_second = (CB_FIRST != 0) ? cv : cu;
    c_sel    = phase ? c_hold : c_first;
  end

  // ---- output stage, phase tracking and line statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yc_out       <= '0;
      phase        <= 1'b0;
      c_hold       <= '0;
      line_cnt     <= '0;
      line_len     <= '0;
      odd_line_err <= 1'b0;
    end else begin
      yc_out <= vld_p2 ? {y_p2, c_sel} : {8'h00, NEUTRAL_C};

      if (vld_p2) begin
        phase <= ~phase;
        if (!phase) begin
          c_hold <= c_second;
        end
      end else begin
        phase <= 1'b0;
      end

      if (vld_p2) begin
        if (line_cnt != '1) begin
          line_cnt <= line_cnt + 1'b1;
        end
      end else if (de_out) begin
        line_len <= line_cnt;
        line_cnt <= '0;
      end

      // Setting beats clearing when a frame starts on the same cycle an odd line closes.
      if (de_out && !vld_p2 && line_cnt[0]) begin
        odd_line_err <= 1'b1;
      end else if (vs_p2 && !vs_out) begin
        odd_line_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_yuv444_to_yuv422.sv
// Scoreboard bench: three configurations of yuv444_to_yuv422 share one randomized video stream.
module tb_yuv444_to_yuv422;

  localparam int NI = 3;
  localparam int QD = 4096;
  localparam int LD = 256;
  localparam int MODE_T [NI] = '{0, 1, 0};
  localparam int CBF_T  [NI] = '{1, 1, 0};
  localparam int MAXL_T [NI] = '{4095, 4095, 15};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] y_in = '0, u_in = '0, v_in = '0;
  logic vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;

  logic [NI-1:0][15:0] yc;
  logic [NI-1:0]       vso, hso, deo, err;
  logic [11:0]         ll0, ll1;
  logic [3:0]          ll2;

  logic [15:0] exp_yc  [NI][QD];
  int          exp_len [NI][LD];
  int          yc_wr [NI], yc_rd [NI], len_wr [NI], len_rd [NI];
  int          line_y [32], line_u [32], line_v [32];
  int          n_checks = 0, n_pass = 0;
  bit          rand_sync = 1'b0;

  always #5 clk = ~clk;

  yuv444_to_yuv422 #(.CHROMA_MODE(0), .CB_FIRST(1), .LINE_W(12)) dut_avg (
    .clk(clk), .rst(rst), .y_in(y_in), .u_in(u_in), .v_in(v_in),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .yc_out(yc[0]), .vs_out(vso[0]), .hs_out(hso[0]), .de_out(deo[0]),
    .line_len(ll0), .odd_line_err(err[0]));

  yuv444_to_yuv422 #(.CHROMA_MODE(1), .CB_FIRST(1), .LINE_W(12)) dut_dec (
    .clk(clk), .rst(rst), .y_in(y_in), .u_in(u_in), .v_in(v_in),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .yc_out(yc[1]), .vs_out(vso[1]), .hs_out(hso[1]), .de_out(deo[1]),
    .line_len(ll1), .odd_line_err(err[1]));

  yuv444_to_yuv422 #(.CHROMA_MODE(0), .CB_FIRST(0), .LINE_W(4)) dut_sat (
    .clk(clk), .rst(rst), .y_in(y_in), .u_in(u_in), .v_in(v_in),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .yc_out(yc[2]), .vs_out(vso[2]), .hs_out(hso[2]), .de_out(deo[2]),
    .line_len(ll2), .odd_line_err(err[2]));

  function automatic int get_len(input int d);
    case (d)
      0:       return int'(ll0);
      1:       return int'(ll1);
      default: return int'(ll2);
    endcase
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
  endtask

  // Reference: pixels pair up from the start of each line; the pair shares one Cb and one Cr.
  task automatic model_line(input int len);
    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < len; i += 2) begin
        int cu, cv, first, second;
        if (MODE_T[d] == 0 && i + 1 < len) begin
          cu = (line_u[i] + line_u[i+1] + 1) / 2;
          cv = (line_v[i] + line_v[i+1] + 1) / 2;
        end else begin
          cu = line_u[i];
          cv = line_v[i];
        end
        first  = (CBF_T[d] != 0) ? cu : cv;
        second = (CBF_T[d] != 0) ? cv : cu;
        exp_yc[d][yc_wr[d] % QD] = 16'((line_y[i] << 8) | first);
        yc_wr[d]++;
        if (i + 1 < len) begin
          exp_yc[d][yc_wr[d] % QD] = 16'((line_y[i+1] << 8) | second);
          yc_wr[d]++;
        end
      end
      exp_len[d][len_wr[d] % LD] = (len > MAXL_T[d]) ? MAXL_T[d] : len;
      len_wr[d]++;
    end
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      line_y[i] = $urandom_range(0, 255);
      line_u[i] = $urandom_range(0, 255);
      line_v[i] = $urandom_range(0, 255);
    end
  endtask

  task automatic drive_px(input int i);
    @(posedge clk); #1;
    y_in  = 8'(line_y[i]);
    u_in  = 8'(line_u[i]);
    v_in  = 8'(line_v[i]);
    de_in = 1'b1;
    vs_in = rand_sync ? ($urandom_range(0, 7) == 0) : 1'b0;
    hs_in = rand_sync ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic idle(input int n, input bit vs_first);
    for (int g = 0; g < n; g++) begin
      @(posedge clk); #1;
      y_in  = 8'($urandom_range(0, 255));
      u_in  = 8'($urandom_range(0, 255));
      v_in  = 8'($urandom_range(0, 255));
      de_in = 1'b0;
      vs_in = (vs_first && g == 0) ? 1'b1 : (rand_sync ? ($urandom_range(0, 3) == 0) : 1'b0);
      hs_in = rand_sync ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  endtask

  task automatic drive_line(input int len, input int gap, input bit vs_end);
    model_line(len);
    for (int i = 0; i < len; i++) drive_px(i);
    idle(gap, vs_end);
  endtask

  // Monitor: outputs are sampled at the falling edge; inputs seen here reach the outputs three falling edges later.
  logic [2:0]    h1 = '0, h2 = '0, h3 = '0;
  logic [NI-1:0] prev_de = '0, prev_vs = '0, exp_err = '0;
  int            settled = 0;

  always @(negedge clk) begin
    if (rst) begin
      settled = 0;
      prev_de = '0;
      prev_vs = '0;
      exp_err = '0;
    end else begin
      if (settled >= 3) begin
        for (int d = 0; d < NI; d++) begin
          chk("sync_align", d, {29'd0, vso[d], hso[d], deo[d]}, {29'd0, h3});
          if (deo[d]) begin
            chk("yc_avail", d, 32'(yc_wr[d] > yc_rd[d]), 32'd1);
            if (yc_wr[d] > yc_rd[d]) begin
              chk("yc_pixel", d, {16'd0, yc[d]}, {16'd0, exp_yc[d][yc_rd[d] % QD]});
              yc_rd[d]++;
            end
          end else begin
            chk("yc_blank", d, {16'd0, yc[d]}, 32'h0080);
          end
          if (!prev_vs[d] && vso[d]) exp_err[d] = 1'b0;
          if (prev_de[d] && !deo[d]) begin
            chk("len_avail", d, 32'(len_wr[d] > len_rd[d]), 32'd1);
            if (len_wr[d] > len_rd[d]) begin
              chk("line_len", d, 32'(get_len(d)), 32'(exp_len[d][len_rd[d] % LD]));
              if (exp_len[d][len_rd[d] % LD] % 2 == 1) exp_err[d] = 1'b1;
              len_rd[d]++;
            end
          end
          chk("odd_line_err", d, {31'd0, err[d]}, {31'd0, exp_err[d]});
        end
      end
      prev_de = deo;
      prev_vs = vso;
      h3 = h2;
      h2 = h1;
      h1 = {vs_in, hs_in, de_in};
      if (settled < 8) settled++;
    end
  end

  task automatic chk_all_zero(input string name);
    for (int d = 0; d < NI; d++) begin
      chk({name, "_yc"}, d, {16'd0, yc[d]}, 32'd0);
      chk({name, "_sync"}, d, {29'd0, vso[d], hso[d], deo[d]}, 32'd0);
      chk({name, "_len"}, d, 32'(get_len(d)), 32'd0);
      chk({name, "_err"}, d, {31'd0, err[d]}, 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < NI; d++) begin
      yc_wr[d] = 0; yc_rd[d] = 0; len_wr[d] = 0; len_rd[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #2 rst = 1'b0;
    idle(4, 1'b0);

    // Averaging / decimation reference line.
    line_y[0:3] = '{10, 20, 30, 40};
    line_u[0:3] = '{100, 103, 50, 50};
    line_v[0:3] = '{200, 201, 0, 255};
    drive_line(4, 3, 1'b0);

    // Odd-length line whose last pixel has no partner.
    fill_random(5);
    line_y[4] = 'h55; line_u[4] = 'h40; line_v[4] = 'h90;
    drive_line(5, 4, 1'b0);

    // Reset after the third pixel of an eight-pixel line.
    fill_random(8);
    model_line(8);
    for (int i = 0; i < 3; i++) drive_px(i);
    @(posedge clk); #1;
    de_in = 1'b0; vs_in = 1'b0; hs_in = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    for (int d = 0; d < NI; d++) begin
      yc_wr[d]  = yc_rd[d];
      len_wr[d] = len_rd[d];
    end
    @(posedge clk); #2 rst = 1'b0;
    idle(4, 1'b0);
    fill_random(6);
    drive_line(6, 3, 1'b0);

    // Odd line raises the flag; a later vs rising edge clears it.
    fill_random(5);
    drive_line(5, 3, 1'b0);
    fill_random(4);
    drive_line(4, 3, 1'b1);

    // Odd line closing on the same cycle vs rises: set wins.
    fill_random(7);
    drive_line(7, 3, 1'b1);

    // Counter saturation on the narrow instance.
    fill_random(20);
    drive_line(20, 3, 1'b0);

    // Randomized lines, glitches (gap of one) and sync activity.
    rand_sync = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int len, gap;
      len = $urandom_range(1, 20);
      gap = $urandom_range(1, 4);
      fill_random(len);
      drive_line(len, gap, $urandom_range(0, 3) == 0);
    end
    rand_sync = 1'b0;
    idle(8, 1'b0);

    for (int d = 0; d < NI; d++) begin
      chk("yc_drained", d, 32'(yc_wr[d] - yc_rd[d]), 32'd0);
      chk("len_drained", d, 32'(len_wr[d] - len_rd[d]), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
